// File: rtl/adder_arbiter_pkg.sv
// Shared types and constants for the adder_arbiter slice: FSM state encoding,
// requester-id width helper and grant-counter width.
package adder_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int STAT_W = 16;

   // Id width for n requesters; never narrower than one bit.
   function automatic int calc_idw(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ripple_adder.sv
// Plain N-bit ripple-carry adder; the carry-out is returned as bit N of the sum.
module ripple_adder #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N:0]   s
);

   logic [N:0] carry;

   assign carry[0] = 1'b0;

   for (genvar gi = 0; gi < N; gi++) begin : g_bit
      assign s[gi]        = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
   end

   assign s[N] = carry[N];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NREQ. Produces a one-hot grant and the matching index.
module rr_arbiter
   import adder_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = calc_idw(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_id
);

   int idx;

   // Walk offsets from farthest to nearest so the closest request to ptr wins.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      idx      = 0;
      for (int off = NREQ - 1; off >= 0; off--) begin
         idx = (int'(ptr) + off) % NREQ;
         if (req[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
            grant_id   = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one ripple adder among NREQ valid/ready requesters.
// Define ADDER_ARBITER_STATS_EN to add per-requester saturating grant counters.
module adder_arbiter
   import adder_arbiter_pkg::*;
#(
   parameter  int N    = 32,
   parameter  int NREQ = 4,
   localparam int IDW  = calc_idw(NREQ)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req_valid,
   input  logic [NREQ*N-1:0] req_a,
   input  logic [NREQ*N-1:0] req_b,
   output logic [NREQ-1:0]  req_ready,
   output logic             rsp_valid,
   output logic [IDW-1:0]   rsp_id,
   output logic [N:0]       rsp_r,
   input  logic             rsp_ready
`ifdef ADDER_ARBITER_STATS_EN
   ,
   input  logic                   stat_clr,
   output logic [NREQ*STAT_W-1:0] stat_grants
`endif
);

   state_t          state_reg, state_next;
   logic [IDW-1:0]  rr_ptr_reg;
   logic [IDW-1:0]  id_reg;
   logic [N-1:0]    op_a_reg, op_b_reg;
   logic            rsp_valid_reg;
   logic [IDW-1:0]  rsp_id_reg;
   logic [N:0]      rsp_r_reg;

   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  win_id;
   logic [IDW-1:0]  ptr_wrap;
   logic [N:0]      sum;
   logic [N-1:0]    a_arr [NREQ];
   logic [N-1:0]    b_arr [NREQ];

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*N +: N];
      assign b_arr[gi] = req_b[gi*N +: N];
   end

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr (
      .req      (req_valid),
      .ptr      (rr_ptr_reg),
      .grant    (grant),
      .grant_id (win_id)
   );

   ripple_adder #(
      .N (N)
   ) u_add (
      .a (op_a_reg),
      .b (op_b_reg),
      .s (sum)
   );

   // Grants are only offered while idle, so the ready vector is at most one-hot.
   assign req_ready = (state_reg == IDLE) ? grant : '0;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_id    = rsp_id_reg;
   assign rsp_r     = rsp_r_reg;
   assign ptr_wrap  = (int'(id_reg) == NREQ - 1) ? '0 : id_reg + 1'b1;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (|grant) state_next = CALC;
         CALC:    state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         rr_ptr_reg    <= '0;
         id_reg        <= '0;
         op_a_reg      <= '0;
         op_b_reg      <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_id_reg    <= '0;
         rsp_r_reg     <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (|grant) begin
                  op_a_reg <= a_arr[win_id];
                  op_b_reg <= b_arr[win_id];
                  id_reg   <= win_id;
               end
            end
            CALC: begin
               // Operands were latched a full cycle ago, so the ripple chain has settled.
               rsp_r_reg     <= sum;
               rsp_id_reg    <= id_reg;
               rsp_valid_reg <= 1'b1;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  rr_ptr_reg    <= ptr_wrap;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ADDER_ARBITER_STATS_EN
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
      logic [STAT_W-1:0] cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt_reg <= '0;
         end else if (stat_clr) begin
            cnt_reg <= '0;
         end else if (req_ready[gi] && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end

      assign stat_grants[gi*STAT_W +: STAT_W] = cnt_reg;
   end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: expected sums go into a scoreboard queue at
// grant time and are popped when the response is accepted.
module tb_adder_arbiter;

   localparam int N    = 32;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*N-1:0] req_a;
   logic [NREQ*N-1:0] req_b;
   logic [NREQ-1:0]   req_ready;
   logic              rsp_valid;
   logic [IDW-1:0]    rsp_id;
   logic [N:0]        rsp_r;
   logic              rsp_ready;
`ifdef ADDER_ARBITER_STATS_EN
   logic                 stat_clr;
   logic [NREQ*16-1:0]   stat_grants;
`endif

   adder_arbiter #(
      .N    (N),
      .NREQ (NREQ)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_r     (rsp_r),
      .rsp_ready (rsp_ready)
`ifdef ADDER_ARBITER_STATS_EN
      ,
      .stat_clr    (stat_clr),
      .stat_grants (stat_grants)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      int         id;
      logic [N:0] r;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   last_grant = -1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int k, input logic [N-1:0] a, input logic [N-1:0] b);
      req_a[k*N +: N] = a;
      req_b[k*N +: N] = b;
      req_valid[k]    = 1'b1;
   endtask

   function automatic logic [N-1:0] rr_a(input int k);
      return 32'h1000_0000 * k + k + 1;
   endfunction

   function automatic logic [N-1:0] rr_b(input int k);
      return 32'hF000_0000 + 32'h0000_0100 * k;
   endfunction

   task automatic pop_check();
      exp_t e;
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("rsp_id", 64'(rsp_id), 64'(e.id));
         chk("rsp_r", 64'(rsp_r), 64'(e.r));
         $display("txn id=%0d r=%0h expected_id=%0d expected_r=%0h", rsp_id, rsp_r, e.id, e.r);
      end
   endtask

   // Entered just after a negedge with requests driven and the DUT idle;
   // returns just after a negedge with the DUT idle again.
   task automatic serve(input int k, input logic [N-1:0] a, input logic [N-1:0] b,
                        input bit drop, input int stall, input int raise, input bit spacing);
      exp_t e;
      rsp_ready = (stall == 0);
      #1;
      chk("grant", 64'(req_ready), 64'd1 << k);
      if (spacing && last_grant >= 0) chk("spacing", 64'(cyc - last_grant), 64'd3);
      last_grant = cyc;
      e.id = k;
      e.r  = {1'b0, a} + {1'b0, b};
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (drop) req_valid[k] = 1'b0;
      if (raise >= 0) req_valid[raise] = 1'b1;
      @(negedge clk);
      #1;
      chk("calc_valid", 64'(rsp_valid), 64'd0);
      chk("calc_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("resp_valid", 64'(rsp_valid), 64'd1);
      for (int i = 0; i < stall; i++) begin
         chk("stall_valid", 64'(rsp_valid), 64'd1);
         chk("stall_r", 64'(rsp_r), 64'(sb[0].r));
         chk("stall_id", 64'(rsp_id), 64'(sb[0].id));
         chk("stall_ready", 64'(req_ready), 64'd0);
         @(posedge clk);
         @(negedge clk);
         #1;
      end
      rsp_ready = 1'b1;
      pop_check();
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("done_valid", 64'(rsp_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
`ifdef ADDER_ARBITER_STATS_EN
      stat_clr  = 1'b0;
`endif
      repeat (2) @(negedge clk);
      #1;
      chk("rst_valid", 64'(rsp_valid), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_id", 64'(rsp_id), 64'd0);
      chk("rst_r", 64'(rsp_r), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;

      // Round robin: everyone held valid, grants must go 0,1,2,3,0 three cycles apart.
      for (int k = 0; k < NREQ; k++) set_req(k, rr_a(k), rr_b(k));
      for (int g = 0; g < 5; g++) serve(g % NREQ, rr_a(g % NREQ), rr_b(g % NREQ), 1'b0, 0, -1, 1'b1);
      req_valid = '0;

      // Single request from requester 2.
      set_req(2, 32'h0000_0003, 32'h0000_0004);
      serve(2, 32'h0000_0003, 32'h0000_0004, 1'b1, 0, -1, 1'b0);
      chk("single_sum", 64'(33'h0_0000_0007), 64'({1'b0, 32'h3} + {1'b0, 32'h4}));

      // Overflow: carry lands in bit N.
      set_req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      serve(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, -1, 1'b0);

      // Backpressure on requester 1 while requester 2 waits; 2 is served afterwards.
      req_a[2*N +: N] = 32'h0000_1234;
      req_b[2*N +: N] = 32'h0000_4321;
      set_req(1, 32'h8000_0001, 32'h8000_0002);
      serve(1, 32'h8000_0001, 32'h8000_0002, 1'b1, 10, 2, 1'b0);
      serve(2, 32'h0000_1234, 32'h0000_4321, 1'b1, 0, -1, 1'b0);

      // Reset while holding a response: it must vanish and the pointer return to 0.
      rsp_ready = 1'b0;
      set_req(1, 32'd5, 32'd7);
      #1;
      chk("pre_rst_grant", 64'(req_ready), 64'd2);
      @(posedge clk);
      #1;
      req_valid = '0;
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
      chk("mid_rst_r", 64'(rsp_r), 64'd0);
      chk("mid_rst_id", 64'(rsp_id), 64'd0);
      @(negedge clk);
      rst       = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         chk("no_stale", 64'(rsp_valid), 64'd0);
      end
      for (int k = 0; k < NREQ; k++) set_req(k, rr_a(k), rr_b(k));
      serve(0, rr_a(0), rr_b(0), 1'b0, 0, -1, 1'b0);
      req_valid = '0;

`ifdef ADDER_ARBITER_STATS_EN
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      #1;
      chk("stat_clr0", 64'(stat_grants), 64'd0);
      for (int i = 0; i < 3; i++) begin
         set_req(1, 32'd10 + i, 32'd20);
         serve(1, 32'd10 + i, 32'd20, 1'b1, 0, -1, 1'b0);
      end
      chk("stat_req1", 64'(stat_grants[31:16]), 64'd3);
      chk("stat_req0", 64'(stat_grants[15:0]), 64'd0);
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      #1;
      chk("stat_clr1", 64'(stat_grants), 64'd0);
`endif

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
